// File: rtl/wave_warp_filter.sv
// wave_warp_filter: 3-stage triangle-wave coordinate warp with per-frame mode/amp shadowing.
// Define WAVE_WARP_ANIMATE_EN to add the per-frame phase accumulator driven by speed_in.
module wave_warp_filter #(
  parameter int PIXEL_WIDTH  = 7,
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10,
  parameter int WRAP_H       = 240,
  parameter int WRAP_V       = 320,
  parameter int PERIOD_LOG2  = 6,
  parameter int AMP_SHIFT    = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [PIXEL_WIDTH-1:0]  data_in,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  input  logic                    data_valid_in,
  input  logic [1:0]              mode_in,
  input  logic [3:0]              amp_in,
  input  logic [PERIOD_LOG2-1:0]  speed_in,
  output logic                    data_valid_out,
  output logic [PIXEL_WIDTH-1:0]  pixel_out,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic [VCOUNT_WIDTH-1:0] vcount_out
);
  localparam int PL = PERIOD_LOG2;
  localparam int CW = (HCOUNT_WIDTH > VCOUNT_WIDTH ? HCOUNT_WIDTH : VCOUNT_WIDTH) + PL + 6;
  typedef logic signed [CW-1:0] sw_t;
  localparam sw_t QUARTER = sw_t'(1 << (PL - 2));

  function automatic sw_t wave_prod(input logic [PL-1:0] t, input logic [3:0] amp);
    logic [PL-1:0] tri_w;
    tri_w = t[PL-1] ? ~t : t;
    return (sw_t'(tri_w) - QUARTER) * sw_t'(amp);
  endfunction

  // Coordinates already outside the image are left alone.
  function automatic sw_t warp(input sw_t c, input sw_t prod, input sw_t w);
    sw_t r;
    r = c + (prod >>> AMP_SHIFT);
    return (c >= w) ? c : r[CW-1] ? r + w : (r >= w) ? r - w : r;
  endfunction

  logic                    w_fs;
  logic [PL-1:0]           w_phase;
  logic [1:0]              r_mode;
  logic [3:0]              r_amp;
  logic                    r1_valid, r2_valid;
  logic [PIXEL_WIDTH-1:0]  r1_data, r2_data;
  logic [HCOUNT_WIDTH-1:0] r1_h, r2_h, w_h;
  logic [VCOUNT_WIDTH-1:0] r1_v, r2_v, w_v;
  logic [PL-1:0]           r1_tv, r1_th;
  logic [1:0]              r2_mode;
  sw_t                     r2_pv, r2_ph;

  assign w_fs = data_valid_in && hcount_in == '0 && vcount_in == '0;

`ifdef WAVE_WARP_ANIMATE_EN
  logic [PL-1:0] r_phase;
  assign w_phase = w_fs ? r_phase + speed_in : r_phase;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) r_phase <= '0;
    else r_phase <= w_phase;
`else
  logic w_unused_speed;
  assign w_unused_speed = ^speed_in;
  assign w_phase = '0;
`endif

  assign w_v = VCOUNT_WIDTH'(warp(sw_t'(r2_v), r2_pv, sw_t'(WRAP_V)));
  assign w_h = HCOUNT_WIDTH'(warp(sw_t'(r2_h), r2_ph, sw_t'(WRAP_H)));

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_mode         <= '0;
      r_amp          <= '0;
      r1_valid       <= 1'b0;
      r1_data        <= '0;
      r1_h           <= '0;
      r1_v           <= '0;
      r1_tv          <= '0;
      r1_th          <= '0;
      r2_valid       <= 1'b0;
      r2_data        <= '0;
      r2_h           <= '0;
      r2_v           <= '0;
      r2_mode        <= '0;
      r2_pv          <= '0;
      r2_ph          <= '0;
      data_valid_out <= 1'b0;
      pixel_out      <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      r_mode         <= w_fs ? mode_in : r_mode;
      r_amp          <= w_fs ? amp_in : r_amp;
      r1_valid       <= data_valid_in;
      r1_data        <= data_in;
      r1_h           <= hcount_in;
      r1_v           <= vcount_in;
      r1_tv          <= hcount_in[PL-1:0] + w_phase;
      r1_th          <= vcount_in[PL-1:0] + w_phase;
      r2_valid       <= r1_valid;
      r2_data        <= r1_data;
      r2_h           <= r1_h;
      r2_v           <= r1_v;
      r2_mode        <= r_mode;
      r2_pv          <= wave_prod(r1_tv, r_amp);
      r2_ph          <= wave_prod(r1_th, r_amp);
      data_valid_out <= r2_valid;
      pixel_out      <= r2_data;
      hcount_out     <= !r2_valid ? '0 : r2_mode[1] ? w_h : r2_h;
      vcount_out     <= !r2_valid ? '0 : r2_mode[0] ? w_v : r2_v;
    end
endmodule
